// File: rtl/data_mem_responder.sv
// data_mem_responder: latency-modelled load/store responder over doubleword-organised, byte-addressable memory.
// Define DMEM_DEBUG_PORTS_EN to expose doublewords 0..5 as DataMem0..DataMem5 outputs.
module data_mem_responder #(
    parameter int DEPTH   = 32,
    parameter int LATENCY = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err
`ifdef DMEM_DEBUG_PORTS_EN
    ,
    output logic [63:0] DataMem0,
    output logic [63:0] DataMem1,
    output logic [63:0] DataMem2,
    output logic [63:0] DataMem3,
    output logic [63:0] DataMem4,
    output logic [63:0] DataMem5
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          write_q, write_d;
    logic [63:0]   addr_q, addr_d;
    logic [63:0]   wdata_q, wdata_d;
    logic [1:0]    size_q, size_d;
    logic          uns_q, uns_d;
    logic [63:0]   rdata_q, rdata_d;
    logic          err_q, err_d;
    logic [63:0]   mem_q [DEPTH];
    logic [63:0]   mem_d [DEPTH];

    logic [AW-1:0] idx;
    logic [5:0]    bit_off;
    logic [2:0]    low_mask;
    logic          err;
    logic [63:0]   word, sh, load_val, mask, mask_sh, merged;

    assign idx      = addr_q[AW+2:3];
    assign bit_off  = {addr_q[2:0], 3'b000};
    assign low_mask = {size_q == 2'd3, size_q[1], |size_q};
    assign err      = (|(addr_q[2:0] & low_mask)) || (|addr_q[63:AW+3]);
    assign word     = mem_q[idx];
    assign sh       = word >> bit_off;
    assign load_val = size_q == 2'd3 ? sh :
                      size_q == 2'd2 ? {{32{~uns_q & sh[31]}}, sh[31:0]} :
                      size_q == 2'd1 ? {{48{~uns_q & sh[15]}}, sh[15:0]} :
                                       {{56{~uns_q & sh[7]}}, sh[7:0]};
    assign mask     = size_q == 2'd3 ? 64'hFFFF_FFFF_FFFF_FFFF :
                      size_q == 2'd2 ? 64'h0000_0000_FFFF_FFFF :
                      size_q == 2'd1 ? 64'h0000_0000_0000_FFFF : 64'h0000_0000_0000_00FF;
    assign mask_sh  = mask << bit_off;
    assign merged   = (word & ~mask_sh) | ((wdata_q << bit_off) & mask_sh);

    assign req_ready  = state_q == IDLE;
    assign resp_valid = state_q == RESP;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        uns_d   = uns_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        mem_d   = mem_q;
        case (state_q)
            IDLE: if (req_valid) begin
                write_d = req_write;
                addr_d  = req_addr;
                wdata_d = req_wdata;
                size_d  = req_size;
                uns_d   = req_unsigned;
                cnt_d   = CW'(LATENCY - 1);
                state_d = WAIT;
            end
            WAIT: if (cnt_q == '0) begin
                state_d = RESP;
                err_d   = err;
                rdata_d = (err || write_q) ? 64'd0 : load_val;
                if (!err && write_q) mem_d[idx] = merged;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
            RESP: if (resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Reset clears storage too, so an aborted store can never land.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
        end
    end

`ifdef DMEM_DEBUG_PORTS_EN
    assign DataMem0 = mem_q[0];
    assign DataMem1 = mem_q[1];
    assign DataMem2 = mem_q[2];
    assign DataMem3 = mem_q[3];
    assign DataMem4 = mem_q[4];
    assign DataMem5 = mem_q[5];
`endif
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: randomized and directed checks of data_mem_responder against a byte-array model.
module tb_data_mem_responder;
    localparam int DEPTH   = 32;
    localparam int LATENCY = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [63:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic [1:0]  req_size = '0;
    logic        req_unsigned = 1'b0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [63:0] resp_rdata;
    logic        resp_err;
`ifdef DMEM_DEBUG_PORTS_EN
    logic [63:0] dm0, dm1, dm2, dm3, dm4, dm5;
`endif

    int errors = 0;
    int checks = 0;
    logic [7:0] mm [8*DEPTH];

    data_mem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_unsigned(req_unsigned), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
`ifdef DMEM_DEBUG_PORTS_EN
        , .DataMem0(dm0), .DataMem1(dm1), .DataMem2(dm2),
        .DataMem3(dm3), .DataMem4(dm4), .DataMem5(dm5)
`endif
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end
    endtask

    task automatic model(input logic w, input logic [63:0] a, input logic [63:0] d,
                         input logic [1:0] s, input logic u,
                         output logic [63:0] exp_d, output logic exp_e);
        int n;
        n = 1 << s;
        exp_d = '0;
        exp_e = (a % 64'(n) != 0) || (a >= 64'(8*DEPTH));
        if (!exp_e) begin
            for (int i = 0; i < n; i++)
                if (w) mm[int'(a) + i] = d[8*i +: 8];
                else   exp_d = exp_d | (64'(mm[int'(a) + i]) << (8*i));
            if (!w && !u && s != 2'd3 && exp_d[8*n-1])
                exp_d = exp_d | (64'hFFFF_FFFF_FFFF_FFFF << (8*n));
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_valid = 1'b0;
        resp_ready = 1'b0;
        #2;
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_rdata", resp_rdata, 64'd0);
        chk("rst_err", 64'(resp_err), 64'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        for (int i = 0; i < 8*DEPTH; i++) mm[i] = 8'h00;
    endtask

    task automatic xact(input logic w, input logic [63:0] a, input logic [63:0] d,
                        input logic [1:0] s, input logic u, input int hold,
                        output logic [63:0] got);
        logic [63:0] exp_d;
        logic exp_e;
        int cyc;
        model(w, a, d, s, u, exp_d, exp_e);
        chk("req_ready_idle", 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        req_write = w;
        req_addr = a;
        req_wdata = d;
        req_size = s;
        req_unsigned = u;
        @(posedge clock); #1;
        // Garbage on the request bus after acceptance must have no effect.
        req_valid = 1'($urandom);
        req_write = 1'($urandom);
        req_addr = {$urandom, $urandom};
        req_wdata = {$urandom, $urandom};
        req_size = 2'($urandom);
        req_unsigned = 1'($urandom);
        cyc = 0;
        while (!resp_valid && cyc < 20) begin
            @(posedge clock); #1;
            cyc++;
        end
        chk("latency", 64'(cyc), 64'(LATENCY));
        got = resp_rdata;
        chk("rdata", resp_rdata, exp_d);
        chk("err", 64'(resp_err), 64'(exp_e));
        chk("req_ready_busy", 64'(req_ready), 64'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clock); #1;
            chk("hold_valid", 64'(resp_valid), 64'd1);
            chk("hold_rdata", resp_rdata, exp_d);
            chk("hold_err", 64'(resp_err), 64'(exp_e));
            chk("hold_req_ready", 64'(req_ready), 64'd0);
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(posedge clock); #1;
        resp_ready = 1'b0;
        chk("resp_done", 64'(resp_valid), 64'd0);
        chk("req_ready_back", 64'(req_ready), 64'd1);
    endtask

    initial begin
        logic [63:0] got;
        logic [63:0] a;
        logic [1:0]  s;
        @(posedge clock); #1;
        do_reset();
        xact(1'b0, 64'h0, 64'h0, 2'd3, 1'b0, 0, got);
        chk("t1_ld0", got, 64'h0);
        xact(1'b1, 64'h8, 64'h1122334455667788, 2'd3, 1'b0, 0, got);
        xact(1'b0, 64'h8, 64'h0, 2'd3, 1'b0, 0, got);
        chk("t2_ld", got, 64'h1122334455667788);
        xact(1'b0, 64'h8, 64'h0, 2'd0, 1'b0, 0, got);
        chk("t2_lb", got, 64'hFFFFFFFFFFFFFF88);
        xact(1'b0, 64'h8, 64'h0, 2'd0, 1'b1, 0, got);
        chk("t2_lbu", got, 64'h88);
        xact(1'b0, 64'hC, 64'h0, 2'd2, 1'b0, 0, got);
        chk("t2_lw", got, 64'h11223344);
        xact(1'b1, 64'h12, 64'hBEEF, 2'd1, 1'b0, 0, got);
        xact(1'b0, 64'h10, 64'h0, 2'd3, 1'b0, 0, got);
        chk("t3_ld", got, 64'h00000000BEEF0000);
        xact(1'b0, 64'h6, 64'h0, 2'd2, 1'b0, 0, got);
        chk("t4_misaligned", got, 64'h0);
        xact(1'b1, 64'h100, 64'hDEADBEEFDEADBEEF, 2'd3, 1'b0, 0, got);
        xact(1'b0, 64'hF8, 64'h0, 2'd3, 1'b0, 0, got);
        chk("t4_unchanged", got, 64'h0);
        xact(1'b0, 64'h8, 64'h0, 2'd3, 1'b0, 5, got);
        chk("t5_hold", got, 64'h1122334455667788);
        xact(1'b1, 64'h0, 64'hAA, 2'd3, 1'b0, 0, got);
        // Abort a store mid-WAIT with reset.
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr = 64'h0;
        req_wdata = 64'hAA;
        req_size = 2'd3;
        @(posedge clock); #1;
        req_valid = 1'b0;
        do_reset();
        xact(1'b0, 64'h0, 64'h0, 2'd3, 1'b0, 0, got);
        chk("t6_ld0", got, 64'h0);
        for (int k = 0; k < 200; k++) begin
            s = 2'($urandom);
            case ($urandom_range(0, 9))
                0:       a = {$urandom, $urandom};
                1:       a = 64'h100 + 64'($urandom_range(0, 7));
                2:       a = 64'($urandom_range(0, 255));
                default: a = 64'($urandom_range(0, 255)) & ~64'((1 << s) - 1);
            endcase
            xact(1'($urandom), a, {$urandom, $urandom}, s, 1'($urandom),
                 $urandom_range(0, 2), got);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
